// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out link bundle: the parallel word and load strobe in,
// the serial line and frame status out.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_Data;
  logic             i_Load;
  logic             o_Serial;
  logic             o_Busy;
  logic             o_Done;

  modport master (
    output i_Data,
    output i_Load,
    input  o_Serial,
    input  o_Busy,
    input  o_Done
  );

  modport slave (
    input  i_Data,
    input  i_Load,
    output o_Serial,
    output o_Busy,
    output o_Done
  );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first serializer with idle-high line, busy and one-cycle done status.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB.
module piso_serializer #(
  parameter int WIDTH    = 8,
  parameter int BIT_CLKS = 1
) (
  input logic               i_CLK,
  input logic               i_RST,
  piso_serializer_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int DIV_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  logic [FRAME-1:0] shift_reg;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] bit_reg;
  logic             serial_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [FRAME-1:0] load_word;

  // The parity bit rides in the LSB slot so it falls out right after the data LSB.
`ifdef PISO_PARITY_EN
  assign load_word = {bus.i_Data, ^bus.i_Data};
`else
  assign load_word = bus.i_Data;
`endif

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      div_reg    <= '0;
      bit_reg    <= '0;
      serial_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.i_Load) begin
            shift_reg  <= load_word;
            serial_reg <= load_word[FRAME-1];
            div_reg    <= '0;
            bit_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_reg == DIV_LAST) begin
            div_reg   <= '0;
            shift_reg <= shift_reg << 1;
            if (bit_reg == BIT_LAST) begin
              bit_reg    <= '0;
              serial_reg <= 1'b1;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              // Output the bit that becomes the MSB after this shift.
              bit_reg    <= bit_reg + 1'b1;
              serial_reg <= shift_reg[FRAME-2];
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_Serial = serial_reg;
  assign bus.o_Busy   = busy_reg;
  assign bus.o_Done   = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Checks two serializer instances (1 and 4 clocks per bit) against a
// bit-list model built from the frame rules.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drive_data;
  logic       drive_load;
  int         sel;
  int         passed = 0;
  int         total  = 0;
  logic       mserial, mbusy, mdone;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus1 ();
  piso_serializer_if #(.WIDTH(8)) bus4 ();

  assign bus1.i_Data = drive_data;
  assign bus4.i_Data = drive_data;
  assign bus1.i_Load = drive_load & (sel != 4);
  assign bus4.i_Load = drive_load & (sel != 1);

  piso_serializer #(.WIDTH(8), .BIT_CLKS(1)) dut1 (.i_CLK(clk), .i_RST(rst), .bus(bus1));
  piso_serializer #(.WIDTH(8), .BIT_CLKS(4)) dut4 (.i_CLK(clk), .i_RST(rst), .bus(bus4));

  assign mserial = (sel == 4) ? bus4.o_Serial : bus1.o_Serial;
  assign mbusy   = (sel == 4) ? bus4.o_Busy   : bus1.o_Busy;
  assign mdone   = (sel == 4) ? bus4.o_Done   : bus1.o_Done;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // One frame on the selected instance. junk_t: cycle index at which a
  // stray load is pulsed (-1 none); rst_t: cycle index at which reset drops
  // (-1 none); chain: load nxt in the done cycle.
  task automatic run_frame(input int bc, input logic [7:0] d, input bit preloaded,
                           input int junk_t, input logic [7:0] junk,
                           input int rst_t, input bit chain, input logic [7:0] nxt);
    logic [8:0] bits;
    sel = bc;
    for (int n = 0; n < 8; n++) bits[n] = d[7-n];
    bits[8] = ^d;
    if (!preloaded) begin
      @(negedge clk);
      drive_data = d;
      drive_load = 1'b1;
    end
    @(posedge clk);
    for (int t = 0; t < NB * bc; t++) begin
      @(negedge clk);
      chk($sformatf("d%0d_%02h_ser_t%0d", bc, d, t), mserial, bits[t / bc]);
      chk($sformatf("d%0d_%02h_busy_t%0d", bc, d, t), mbusy, 1'b1);
      chk($sformatf("d%0d_%02h_done_t%0d", bc, d, t), mdone, 1'b0);
      drive_load = (t == junk_t);
      drive_data = (t == junk_t) ? junk : 8'($urandom);
      if (t == rst_t) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ser", mserial, 1'b1);
        chk("abort_busy", mbusy, 1'b0);
        chk("abort_done", mdone, 1'b0);
        @(negedge clk);
        chk("abort_done_next", mdone, 1'b0);
        chk("abort_busy_next", mbusy, 1'b0);
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("d%0d_%02h_end_done", bc, d), mdone, 1'b1);
    chk($sformatf("d%0d_%02h_end_busy", bc, d), mbusy, 1'b0);
    chk($sformatf("d%0d_%02h_end_ser", bc, d), mserial, 1'b1);
    if (chain) begin
      drive_load = 1'b1;
      drive_data = nxt;
    end else begin
      drive_load = 1'b0;
      @(negedge clk);
      chk($sformatf("d%0d_%02h_post_done", bc, d), mdone, 1'b0);
      chk($sformatf("d%0d_%02h_post_busy", bc, d), mbusy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rd;
    sel        = 0;
    rst        = 1'b0;
    drive_load = 1'b1;
    drive_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_ser1_%0d", i), bus1.o_Serial, 1'b1);
      chk($sformatf("rst_busy1_%0d", i), bus1.o_Busy, 1'b0);
      chk($sformatf("rst_done1_%0d", i), bus1.o_Done, 1'b0);
      chk($sformatf("rst_ser4_%0d", i), bus4.o_Serial, 1'b1);
      chk($sformatf("rst_busy4_%0d", i), bus4.o_Busy, 1'b0);
      chk($sformatf("rst_done4_%0d", i), bus4.o_Done, 1'b0);
    end
    drive_load = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("idle_busy1", bus1.o_Busy, 1'b0);
    chk("idle_busy4", bus4.o_Busy, 1'b0);

    run_frame(1, 8'hA5, 0, -1, 8'h00, -1, 0, 8'h00);
    run_frame(4, 8'h81, 0, -1, 8'h00, -1, 0, 8'h00);
    run_frame(1, 8'h3C, 0, 3, 8'hFF, -1, 0, 8'h00);
    run_frame(4, 8'h3C, 0, 12, 8'hFF, -1, 0, 8'h00);
    run_frame(1, 8'h96, 0, -1, 8'h00, 4, 0, 8'h00);
    run_frame(1, 8'h0F, 0, -1, 8'h00, -1, 1, 8'hF0);
    run_frame(1, 8'hF0, 1, -1, 8'h00, -1, 0, 8'h00);
    run_frame(1, 8'h07, 0, -1, 8'h00, -1, 0, 8'h00);
    run_frame(4, 8'hC3, 0, -1, 8'h00, 17, 0, 8'h00);

    for (int i = 0; i < 8; i++) begin
      int bc;
      bc = (i % 2 == 1) ? 4 : 1;
      rd = 8'($urandom);
      run_frame(bc, rd, 0, int'($urandom_range(0, NB * bc - 2)), 8'($urandom),
                -1, 1, ~rd);
      run_frame(bc, ~rd, 1, -1, 8'h00, -1, 0, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
